// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer pipeline stage that registers the payload toward downstream.
// Optional stall/bubble performance counters are enabled by defining PIPE_SKID_PERF_CNT_EN.
`timescale 1ns/1ps
module pipe_skid_stage #(
    parameter int PAYLOAD_W = 71,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    input  logic                 clr_cnt,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PAYLOAD_W-1:0]   main_q, main_d;
    logic [PAYLOAD_W-1:0]   skid_q, skid_d;
    logic                   accept;
    logic                   issue;

    // Handshake outputs depend on registered state only, so out_ready never reaches in_ready.
    assign in_ready    = (state_q != FULL);
    assign out_valid   = (state_q != EMPTY);
    assign out_payload = main_q;
    assign accept      = in_valid && in_ready;
    assign issue       = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    main_d  = in_payload;
                end
            end
            ONE: begin
                if (accept && issue) begin
                    main_d = in_payload;
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = in_payload;
                end else if (issue) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (issue) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush drops every held entry; out_payload keeps showing its last value.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_SKID_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (v == {CNT_W{1'b1}}) ? v : v + one;
    endfunction

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (clr_cnt) begin
            stall_d  = '0;
            bubble_d = '0;
        end else begin
            if (out_valid && !out_ready) stall_d = sat_inc(stall_q);
            if (!out_valid && out_ready) bubble_d = sat_inc(bubble_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign stall_cnt      = '0;
    assign bubble_cnt     = '0;
`endif

endmodule
